// File: rtl/iu_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// Holds the run-state encoding and the word parity function.
package iu_pkg;

    typedef enum logic [1:0] {
        IU_IDLE = 2'd0,
        IU_RUN  = 2'd1,
        IU_HALT = 2'd2
    } iu_state_e;

    localparam int IU_PAR_W = 64;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic iu_parity(input logic [IU_PAR_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/iu_imem.sv
// Instruction memory: sync write, combinational read, not reset.
// With IU_PARITY_EN each word carries an even-parity bit checked on read.
module iu_imem
    import iu_pkg::*;
#(
    parameter int INSTR_W = 13,
    parameter int ADDR_W  = 5
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]  i_raddr,
    output logic [INSTR_W-1:0] o_rdata,
    output logic               o_par_bad
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef IU_PARITY_EN
    logic [INSTR_W:0] r_mem [DEPTH];
    logic [INSTR_W:0] w_rword;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= {iu_parity(IU_PAR_W'(i_wdata)), i_wdata};
        end
    end

    assign w_rword   = r_mem[i_raddr];
    assign o_rdata   = w_rword[INSTR_W-1:0];
    assign o_par_bad = w_rword[INSTR_W]
                     ^ iu_parity(IU_PAR_W'(w_rword[INSTR_W-1:0]));
`else
    logic [INSTR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata   = r_mem[i_raddr];
    assign o_par_bad = 1'b0;
`endif

endmodule

// File: rtl/iu_fetch.sv
// Instruction fetch: run FSM, PC, IR with valid/ready, branch and halt.
// Define IU_PARITY_EN to enable per-word parity and sticky parity_err.
module iu_fetch
    import iu_pkg::*;
#(
    parameter int INSTR_W = 13,
    parameter int ADDR_W  = 5,
    parameter int WRAP    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               write_enable,
    input  logic [ADDR_W-1:0]  write_address,
    input  logic [INSTR_W-1:0] write_data,
    input  logic               start,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               running,
    output logic               halted,
    output logic               parity_err
);

    localparam logic [ADDR_W-1:0] LAST_PC = '1;

    iu_state_e          r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [ADDR_W-1:0]  r_ir_pc;
    logic               r_valid;
    logic               r_perr;

    logic [INSTR_W-1:0] w_rdata;
    logic               w_par_bad;
    logic               w_run;
    logic               w_fetch;

    iu_imem #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) u_imem (
        .clk       (clk),
        .i_we      (write_enable),
        .i_waddr   (write_address),
        .i_wdata   (write_data),
        .i_raddr   (r_pc),
        .o_rdata   (w_rdata),
        .o_par_bad (w_par_bad)
    );

    assign w_run   = (r_state == IU_RUN);
    assign w_fetch = w_run && !branch_en && (!r_valid || ir_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IU_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_ir_pc <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
        end else if (start) begin
            r_state <= IU_RUN;
            r_pc    <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
        end else if (w_run && branch_en) begin
            // The in-flight word is dropped even if decode accepts it.
            r_valid <= 1'b0;
            r_pc    <= branch_target;
        end else if (w_fetch) begin
            r_ir    <= w_rdata;
            r_ir_pc <= r_pc;
            r_valid <= 1'b1;
            r_pc    <= r_pc + 1'b1;
            if (w_par_bad) begin
                r_perr <= 1'b1;
            end
            if (r_pc == LAST_PC && WRAP == 0) begin
                r_state <= IU_HALT;
            end
        end else if (r_valid && ir_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign ir_out     = r_ir;
    assign ir_valid   = r_valid;
    assign ir_pc      = r_ir_pc;
    assign running    = w_run;
    assign halted     = (r_state == IU_HALT);
    assign parity_err = r_perr;

endmodule
